// File: rtl/uart_rx_word_packer_if.sv
// Bus between the UART receiver/packer and its surroundings: RX pin, clear,
// received-byte status and the note-memory write port.
interface uart_rx_word_packer_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              uart_rx;
    logic              clr;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              frame_err;
    logic              parity_err;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;

    // Environment side: drives the line and clear, observes results
    modport master (
        output uart_rx, clr,
        input  byte_valid, byte_data, frame_err, parity_err, wr_en, wr_addr, wr_data
    );

    // Receiver side
    modport slave (
        input  uart_rx, clr,
        output byte_valid, byte_data, frame_err, parity_err, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/uart_rx_word_packer.sv
// UART receiver (oversampled, 3-sample mid-bit vote) feeding a 3-byte -> 2x12-bit
// word packer that writes into the note memory with an auto-incrementing address.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing with parity check);
// when undefined the receiver is 8N1 and parity_err is held low.
module uart_rx_word_packer #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                   clk,
    input logic                   rst,
    uart_rx_word_packer_if.slave  bus
);

    localparam int unsigned DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned S_LO  = OVERSAMPLE / 2 - 1;
    localparam int unsigned S_MID = OVERSAMPLE / 2;
    localparam int unsigned S_HI  = OVERSAMPLE / 2 + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HI
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic [DIV_W-1:0]       div_cnt;
    logic                   tick;
    logic [1:0]             vote;
    logic                   samp;
    logic                   sample_now;

    state_t     state, state_n;
    logic [OS_W-1:0] tcnt, tcnt_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] byte_data_n;
    logic       byte_valid_n;
    logic       frame_err_n;
`ifdef UART_RX_PARITY_EN
    logic       par_bit, par_bit_n;
    logic       parity_err_n;
`endif

    logic [1:0] phase;
    logic [7:0] hold;

    // RX synchroniser, idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '1;
        else     sync <= {sync[SYNC_STAGES-2:0], bus.uart_rx};
    end

    assign rx_s = sync[SYNC_STAGES-1];

    // Free-running oversample tick divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    // Capture the first two of the three mid-bit votes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote <= 2'b11;
        end else if (tick) begin
            if (tcnt == OS_W'(S_LO))  vote[0] <= rx_s;
            if (tcnt == OS_W'(S_MID)) vote[1] <= rx_s;
        end
    end

    assign sample_now = tick && (tcnt == OS_W'(S_HI));
    assign samp       = (vote[0] & vote[1]) | (vote[0] & rx_s) | (vote[1] & rx_s);

    // Receiver FSM state and registered byte outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            tcnt           <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            bus.byte_data  <= '0;
            bus.byte_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit        <= 1'b0;
            bus.parity_err <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            tcnt           <= tcnt_n;
            bit_idx        <= bit_idx_n;
            shreg          <= shreg_n;
            bus.byte_data  <= byte_data_n;
            bus.byte_valid <= byte_valid_n;
            bus.frame_err  <= frame_err_n;
`ifdef UART_RX_PARITY_EN
            par_bit        <= par_bit_n;
            bus.parity_err <= parity_err_n;
`endif
        end
    end

`ifndef UART_RX_PARITY_EN
    assign bus.parity_err = 1'b0;
`endif

    // Receiver FSM next-state and output decode; all decisions on the voted mid-bit sample
    always_comb begin
        state_n      = state;
        tcnt_n       = tcnt;
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        byte_data_n  = bus.byte_data;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n    = par_bit;
        parity_err_n = 1'b0;
`endif
        if (tick) tcnt_n = (tcnt == OS_W'(OVERSAMPLE - 1)) ? '0 : tcnt + OS_W'(1);

        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n = S_START;
                    tcnt_n  = '0;
                end
            end
            S_START: begin
                if (sample_now) begin
                    state_n   = samp ? S_IDLE : S_DATA;
                    bit_idx_n = '0;
                end
            end
            S_DATA: begin
                if (sample_now) begin
                    shreg_n   = {samp, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == 3'd7) state_n = S_PARITY;
`else
                    if (bit_idx == 3'd7) state_n = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample_now) begin
                    par_bit_n = samp;
                    state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (sample_now) begin
                    if (!samp) begin
                        frame_err_n = 1'b1;
                        state_n     = S_WAIT_HI;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (^{shreg, par_bit}) begin
                        parity_err_n = 1'b1;
                        state_n      = S_IDLE;
                    end
`endif
                    else begin
                        byte_valid_n = 1'b1;
                        byte_data_n  = shreg;
                        state_n      = S_IDLE;
                    end
                end
            end
            S_WAIT_HI: begin
                if (rx_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Packer: 3 bytes -> 2 words, write one cycle after byte_valid, address bumps after each write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= 2'd0;
            hold        <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            if (bus.wr_en) bus.wr_addr <= bus.wr_addr + ADDR_W'(1);
            if (bus.clr) begin
                phase       <= 2'd0;
                bus.wr_addr <= '0;
            end else if (bus.frame_err || bus.parity_err) begin
                phase <= 2'd0;
            end else if (bus.byte_valid) begin
                case (phase)
                    2'd0: begin
                        hold  <= bus.byte_data;
                        phase <= 2'd1;
                    end
                    2'd1: begin
                        bus.wr_data <= {hold, bus.byte_data[7:4]};
                        bus.wr_en   <= 1'b1;
                        hold        <= bus.byte_data;
                        phase       <= 2'd2;
                    end
                    default: begin
                        bus.wr_data <= {hold[3:0], bus.byte_data};
                        bus.wr_en   <= 1'b1;
                        phase       <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Scoreboard bench for uart_rx_word_packer: a bench-side packer model queues
// expected bytes and writes; a negedge monitor pops and compares DUT output.
module tb_uart_rx_word_packer;

    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned BIT_CLK = 160;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    uart_rx_word_packer_if #(.ADDR_W(ADDR_W)) bus ();

    uart_rx_word_packer #(
        .CLK_HZ     (1600000),
        .BAUD       (10000),
        .OVERSAMPLE (16),
        .ADDR_W     (ADDR_W),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [11:0]       data;
    } wr_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          frame_seen  = 0;
    int          parity_seen = 0;
    logic [7:0]  byte_q[$];
    wr_t         wr_q[$];
    wr_t         mon_w;

    int          m_phase = 0;
    logic [7:0]  m_hold  = '0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic        clr_hit = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic        par_flip = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Bench-side packer model: expected byte plus any resulting write
    task automatic model_byte(input logic [7:0] b, input bit cleared);
        wr_t w;
        byte_q.push_back(b);
        if (cleared) begin
            m_phase = 0;
            m_addr  = '0;
        end else if (m_phase == 0) begin
            m_hold  = b;
            m_phase = 1;
        end else if (m_phase == 1) begin
            w.addr = m_addr;
            w.data = {m_hold, b[7:4]};
            wr_q.push_back(w);
            m_addr  = m_addr + ADDR_W'(1);
            m_hold  = b;
            m_phase = 2;
        end else begin
            w.addr = m_addr;
            w.data = {m_hold[3:0], b};
            wr_q.push_back(w);
            m_addr  = m_addr + ADDR_W'(1);
            m_phase = 0;
        end
    endtask

    task automatic model_clr();
        m_phase = 0;
        m_addr  = '0;
    endtask

    // Drive one frame; optionally raise clr in the cycle byte_valid is high
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit clr_on_valid);
        bus.uart_rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        bus.uart_rx = (^b) ^ par_flip;
        repeat (BIT_CLK) @(negedge clk);
`endif
        bus.uart_rx = stop;
        clr_hit = 1'b0;
        for (int i = 0; i < int'(BIT_CLK) + 20; i++) begin
            @(negedge clk);
            if (clr_on_valid) begin
                bus.clr = bus.byte_valid;
                if (bus.byte_valid) clr_hit = 1'b1;
            end
        end
        bus.clr = 1'b0;
    endtask

    task automatic send_good(input logic [7:0] b);
        model_byte(b, 1'b0);
        send_frame(b, 1'b1, 1'b0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        model_clr();
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.byte_valid) begin
                check("byte_pending", 32'(byte_q.size() != 0), 32'd1);
                if (byte_q.size() != 0) check("byte_data", 32'(bus.byte_data), 32'(byte_q.pop_front()));
            end
            if (bus.wr_en) begin
                check("wr_pending", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    mon_w = wr_q.pop_front();
                    check("wr_addr", 32'(bus.wr_addr), 32'(mon_w.addr));
                    check("wr_data", 32'(bus.wr_data), 32'(mon_w.data));
                end
            end
            if (bus.frame_err)  frame_seen++;
            if (bus.parity_err) parity_seen++;
        end
    end

    initial begin
        bus.uart_rx = 1'b1;
        bus.clr     = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
        check("rst_byte_data",  32'(bus.byte_data),  32'd0);
        check("rst_frame_err",  32'(bus.frame_err),  32'd0);
        check("rst_parity_err", 32'(bus.parity_err), 32'd0);
        check("rst_wr_en",      32'(bus.wr_en),      32'd0);
        check("rst_wr_addr",    32'(bus.wr_addr),    32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Basic three-byte pack
        send_good(8'h12);
        send_good(8'h34);
        send_good(8'h56);
        check("addr_after_pack", 32'(bus.wr_addr), 32'(m_addr));

        // Short low glitch must be rejected
        bus.uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("glitch_no_frame_err", 32'(frame_seen), 32'd0);

        // Framing error, long break, then realigned packing
        pulse_clr();
        send_frame(8'hA5, 1'b0, 1'b0);
        m_phase = 0;
        repeat (3 * BIT_CLK) @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        check("frame_err_count", 32'(frame_seen), 32'd1);
        send_good(8'h01);
        send_good(8'h02);
        send_good(8'h03);

        // Address wrap with a 2-bit address
        pulse_clr();
        for (int i = 0; i < 9; i++) send_good(8'(8'h30 + i));
        check("addr_after_wrap", 32'(bus.wr_addr), 32'(m_addr));

        // clr discards a held byte
        send_good(8'hFF);
        pulse_clr();
        send_good(8'hAB);
        send_good(8'hCD);
        send_good(8'hEF);

        // clr coincident with byte_valid drops that byte from packing
        model_byte(8'h11, 1'b1);
        send_frame(8'h11, 1'b1, 1'b1);
        check("clr_coincident", 32'(clr_hit), 32'd1);
        check("addr_after_clr", 32'(bus.wr_addr), 32'd0);
        send_good(8'h22);
        send_good(8'h33);
        send_good(8'h44);

`ifdef UART_RX_PARITY_EN
        // Bad parity drops byte and realigns; good parity passes
        pulse_clr();
        par_flip = 1'b1;
        send_frame(8'h0F, 1'b1, 1'b0);
        m_phase  = 0;
        par_flip = 1'b0;
        check("parity_err_count", 32'(parity_seen), 32'd1);
        send_good(8'h0F);
        check("parity_ok_byte", 32'(bus.byte_data), 32'h0F);
`endif

        // Reset in the middle of a frame aborts it silently
        bus.uart_rx = 1'b0;
        repeat (5 * BIT_CLK) @(negedge clk);
        rst = 1'b1;
        bus.uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_clr();
        repeat (12 * BIT_CLK) @(negedge clk);
        check("midrst_byte_data", 32'(bus.byte_data), 32'd0);
        check("midrst_wr_addr",   32'(bus.wr_addr),   32'd0);
        send_good(8'h5A);
        send_good(8'hC3);

        repeat (200) @(negedge clk);
        check("byte_q_left", 32'(byte_q.size()), 32'd0);
        check("wr_q_left",   32'(wr_q.size()),   32'd0);
        check("frame_total", 32'(frame_seen),    32'd1);
`ifdef UART_RX_PARITY_EN
        check("parity_total", 32'(parity_seen), 32'd1);
`else
        check("parity_total", 32'(parity_seen), 32'd0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
